// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key code width and
// the one-cold column drive table.
package keypad_scanner_pkg;

    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drive;
        case (idx)
            2'd0:    drive = 4'b1110;
            2'd1:    drive = 4'b1101;
            2'd2:    drive = 4'b1011;
            default: drive = 4'b0111;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/keypad_row_encoder.sv
// Active-low row sense lines -> {hit, row index}. Row 0 has the highest priority.
module keypad_row_encoder (
    input  logic [3:0] rows_in_n,
    output logic       hit,
    output logic [1:0] row_idx
);

    logic [3:0] rows;

    assign rows = ~rows_in_n;
    assign hit  = |rows;

    // Walk from the top down so the lowest asserted row is written last.
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows[i]) row_idx = 2'(i);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, row sampling, press/release debounce
// and key encoding into a held buffer with a one-cycle valid pulse.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SETTLE_CYC   = 2,
    parameter int DEBOUNCE_CNT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                  div_clk,
    input  logic                  rst,
    input  logic [3:0]            keypad_row,
    output logic [3:0]            keypad_col,
    output logic [KEY_CODE_W-1:0] keypad_buf,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_ACCEPT  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] DEB_RELEASE = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e                state_q, state_d;
    logic [1:0]            col_idx_q, col_idx_d;
    logic [CNT_W-1:0]      settle_q, settle_d;
    logic [CNT_W-1:0]      deb_q, deb_d;
    logic [KEY_CODE_W-1:0] cand_q, cand_d;
    logic [3:0]            keypad_col_q, keypad_col_d;
    logic [KEY_CODE_W-1:0] keypad_buf_q, keypad_buf_d;
    logic                  key_valid_q, key_valid_d;
    logic                  key_held_q, key_held_d;

    logic       hit;
    logic [1:0] row_idx;

    keypad_row_encoder u_row_enc (
        .rows_in_n (keypad_row),
        .hit       (hit),
        .row_idx   (row_idx)
    );

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        settle_d     = settle_q;
        deb_d        = deb_q;
        cand_d       = cand_q;
        keypad_buf_d = keypad_buf_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;

        case (state_q)
            SCAN: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    if (hit) begin
                        cand_d  = {row_idx, col_idx_q};
                        deb_d   = CNT_ONE;
                        state_d = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    settle_d = settle_q + CNT_ONE;
                end
            end
            DEBOUNCE: begin
                if (hit && row_idx == cand_q[3:2]) begin
                    if (deb_q >= DEB_ACCEPT) begin
                        keypad_buf_d = cand_q;
                        key_valid_d  = 1'b1;
                        key_held_d   = 1'b1;
                        deb_d        = '0;
                        state_d      = HELD;
                    end else begin
                        deb_d = deb_q + CNT_ONE;
                    end
                end else begin
                    // Bounce or a different row: rescan the same column from a fresh settle.
                    deb_d    = '0;
                    settle_d = '0;
                    state_d  = SCAN;
                end
            end
            HELD: begin
                if (hit) begin
                    deb_d = '0;
                end else if (deb_q >= DEB_RELEASE) begin
                    key_held_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                    settle_d   = '0;
                    deb_d      = '0;
                    state_d    = SCAN;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end
            default: begin
                deb_d    = '0;
                settle_d = '0;
                state_d  = SCAN;
            end
        endcase

        keypad_col_d = col_drive(col_idx_d);
    end

    always_ff @(posedge div_clk) begin
        if (!rst) begin
            state_q      <= SCAN;
            col_idx_q    <= 2'd0;
            settle_q     <= '0;
            deb_q        <= '0;
            cand_q       <= '0;
            keypad_col_q <= 4'b1110;
            keypad_buf_q <= '0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            settle_q     <= settle_d;
            deb_q        <= deb_d;
            cand_q       <= cand_d;
            keypad_col_q <= keypad_col_d;
            keypad_buf_q <= keypad_buf_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign keypad_col = keypad_col_q;
    assign keypad_buf = keypad_buf_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a switch-matrix model drives the rows, presses
// push their expected code/latency, and a monitor checks every key_valid against them.
module tb_keypad_scanner;

    localparam int SETTLE = 2;
    localparam int DEB    = 4;

    logic       div_clk = 1'b0;
    logic       rst     = 1'b0;
    logic [3:0] keypad_row;
    logic [3:0] keypad_col;
    logic [3:0] keypad_buf;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] pressed;   // [row][col] switch closures
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    logic rst_at_edge = 1'b1;
    logic [3:0] prev_buf = '0;

    logic [3:0] exp_code_q[$];
    int         exp_cyc_q[$];

    keypad_scanner #(
        .SETTLE_CYC   (SETTLE),
        .DEBOUNCE_CNT (DEB),
        .CNT_W        (4)
    ) dut (
        .div_clk    (div_clk),
        .rst        (rst),
        .keypad_row (keypad_row),
        .keypad_col (keypad_col),
        .keypad_buf (keypad_buf),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    always #5 div_clk = ~div_clk;

    always @(posedge div_clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rst;
    end

    // A closed switch pulls its row low only while its column is driven low.
    always_comb begin
        keypad_row = 4'hF;
        for (int r = 0; r < 4; r++)
            keypad_row[r] = ~|(pressed[r] & ~keypad_col);
    end

    function automatic logic [3:0] onecold(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c] = 1'b0;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a key.
    always @(negedge div_clk) begin
        if (mon_en) begin
            check("col_onecold", $countones(~keypad_col), 1);
            if (!rst_at_edge && !key_valid && keypad_buf != prev_buf)
                check("buf_stable", keypad_buf, prev_buf);
            if (key_valid) begin
                if (exp_code_q.size() == 0) begin
                    fail_now("unexpected_key_valid");
                end else begin
                    logic [3:0] ec;
                    int         et;
                    ec = exp_code_q.pop_front();
                    et = exp_cyc_q.pop_front();
                    check("key_code", keypad_buf, ec);
                    if (et >= 0) check("valid_latency", cyc, et);
                end
            end
            prev_buf = keypad_buf;
        end
    end

    task automatic set_col(input int c, input logic [3:0] mask);
        for (int r = 0; r < 4; r++) pressed[r][c] = mask[r];
    endtask

    // Returns on the first negedge of a fresh visit to column c.
    task automatic wait_col_fresh(input int c, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (keypad_col == onecold(c) && n < 200) begin @(negedge div_clk); n++; end
        while (keypad_col != onecold(c) && n < 200) begin @(negedge div_clk); n++; end
        ok = (n < 200);
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!key_valid && n < 300) begin @(negedge div_clk); n++; end
        ok = key_valid;
    endtask

    task automatic press(input int c, input logic [3:0] mask, input int bounce, input bit relbounce);
        bit         ok;
        int         c0, low;
        logic [3:0] code;
        low = 0;
        for (int r = 3; r >= 0; r--) if (mask[r]) low = r;
        code = 4'((low << 2) | c);
        wait_col_fresh(c, ok);
        if (!ok) begin fail_now("timeout_col_fresh"); return; end
        c0 = cyc;
        exp_code_q.push_back(code);
        exp_cyc_q.push_back(bounce == 0 ? c0 + SETTLE + DEB : -1);
        if (bounce > 0) begin
            for (int i = 0; i < bounce; i++) begin
                set_col(c, (i % 2 == 0) ? mask : 4'h0);
                @(negedge div_clk);
            end
        end
        set_col(c, mask);
        wait_valid(ok);
        if (!ok) begin fail_now("timeout_key_valid"); set_col(c, 4'h0); return; end
        check("held_at_accept", key_held, 1);
        repeat ($urandom_range(0, 5)) @(negedge div_clk);
        if (relbounce) begin
            set_col(c, 4'h0);
            repeat (3) @(negedge div_clk);
            set_col(c, mask);
            @(negedge div_clk);
            check("held_through_release_bounce", key_held, 1);
        end
        set_col(c, 4'h0);
        repeat (DEB - 1) @(negedge div_clk);
        check("held_before_release", key_held, 1);
        @(negedge div_clk);
        check("held_after_release", key_held, 0);
        check("col_after_release", keypad_col, onecold((c + 1) % 4));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        pressed = '0;

        // Reset: three edges with rows idle, then watch the column rotation.
        rst = 1'b0;
        repeat (3) @(negedge div_clk);
        check("rst_col", keypad_col, 4'b1110);
        check("rst_buf", keypad_buf, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        prev_buf = keypad_buf;
        mon_en = 1'b1;
        rst = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) @(negedge div_clk);
            check("scan_rotation", keypad_col, onecold((j / SETTLE) % 4));
        end

        // Reset during debounce: two matching samples, then reset.
        wait_col_fresh(1, ok);
        if (!ok) fail_now("timeout_col_fresh");
        set_col(1, 4'b0010);
        repeat (3) @(negedge div_clk);
        rst = 1'b0;
        repeat (2) @(negedge div_clk);
        set_col(1, 4'h0);
        check("mid_deb_rst_col", keypad_col, 4'b1110);
        check("mid_deb_rst_held", key_held, 0);
        check("mid_deb_rst_valid", key_valid, 0);
        rst = 1'b1;
        repeat (20) @(negedge div_clk);
        check("mid_deb_buf", keypad_buf, 0);
        check("mid_deb_held", key_held, 0);

        // Directed presses.
        press(1, 4'b0010, 0, 1'b0);   // row1,col1 -> 5
        press(3, 4'b0100, 10, 1'b0);  // bouncing row2,col3 -> B
        press(2, 4'b1001, 0, 1'b0);   // rows 0 and 3 on col2 -> 2
        press(3, 4'b1000, 0, 1'b0);   // row3,col3 -> F
        press(0, 4'b0001, 0, 1'b1);   // code 0 with release bounce

        // Randomized presses.
        for (int k = 0; k < 12; k++) begin
            int         c;
            logic [3:0] m;
            c = $urandom_range(0, 3);
            m = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) m = 4'(1 << $urandom_range(0, 3));
            press(c, m, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : 0,
                  1'($urandom_range(0, 1)));
        end

        repeat (20) @(negedge div_clk);
        check("scoreboard_drained", exp_code_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
